// File: rtl/braille_pkg.sv
// Shared types and constants for the braille record/playback path and its decoder.
// Cell bit n corresponds to dot n+1; a set bit means the dot is raised.
package braille_pkg;

    localparam int CELL_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    localparam logic [CELL_W-1:0] CELL_A = 6'b000001;
    localparam logic [CELL_W-1:0] CELL_B = 6'b000011;
    localparam logic [CELL_W-1:0] CELL_C = 6'b001001;
    localparam logic [CELL_W-1:0] CELL_D = 6'b011001;
    localparam logic [CELL_W-1:0] CELL_E = 6'b010001;
    localparam logic [CELL_W-1:0] CELL_F = 6'b001011;
    localparam logic [CELL_W-1:0] CELL_G = 6'b011011;
    localparam logic [CELL_W-1:0] CELL_H = 6'b010011;
    localparam logic [CELL_W-1:0] CELL_I = 6'b001010;
    localparam logic [CELL_W-1:0] CELL_J = 6'b011010;
    localparam logic [CELL_W-1:0] CELL_K = 6'b000101;
    localparam logic [CELL_W-1:0] CELL_L = 6'b000111;
    localparam logic [CELL_W-1:0] CELL_M = 6'b001101;
    localparam logic [CELL_W-1:0] CELL_N = 6'b011101;
    localparam logic [CELL_W-1:0] CELL_O = 6'b010101;
    localparam logic [CELL_W-1:0] CELL_P = 6'b001111;
    localparam logic [CELL_W-1:0] CELL_Q = 6'b011111;
    localparam logic [CELL_W-1:0] CELL_R = 6'b010111;
    localparam logic [CELL_W-1:0] CELL_S = 6'b001110;
    localparam logic [CELL_W-1:0] CELL_T = 6'b011110;
    localparam logic [CELL_W-1:0] CELL_U = 6'b100101;
    localparam logic [CELL_W-1:0] CELL_V = 6'b100111;
    localparam logic [CELL_W-1:0] CELL_W_ = 6'b111010;
    localparam logic [CELL_W-1:0] CELL_X = 6'b101101;
    localparam logic [CELL_W-1:0] CELL_Y = 6'b111101;
    localparam logic [CELL_W-1:0] CELL_Z = 6'b110101;

endpackage

// File: rtl/braille_sequencer_debounce.sv
// key_debounce: synchronises a raw active-low pushbutton, filters bounce and
// emits a single-cycle pulse on each accepted released-to-pressed transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync_p0     <= 1'b1;
            sync_p1     <= 1'b1;
            level       <= 1'b1;
            stable_cnt  <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_p0     <= key_n;
            sync_p1     <= sync_p0;
            press_pulse <= 1'b0;
            // any return to the accepted level restarts the stability window
            if (sync_p1 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level       <= sync_p1;
                stable_cnt  <= '0;
                press_pulse <= ~sync_p1;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/braille_sequencer.sv
// Record/playback of 6-dot braille cells from switches to the cell decoder.
// Define BRAILLE_SEQ_LOOP_EN for continuous looping with play-to-stop.
module braille_sequencer
    import braille_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int DWELL_CYCLES    = 50_000_000,
    parameter int GAP_CYCLES      = 12_500_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET_N,
    input  logic [CELL_W-1:0]            sw_cell,
    input  logic                         key_store_n,
    input  logic                         key_play_n,
    input  logic                         key_clear_n,
    output logic [CELL_W-1:0]            cell_out,
    output logic                         cell_valid,
    output logic                         busy,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH)-1:0]     play_idx
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int T_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int T_W   = $clog2(T_MAX + 1);

    logic store_pulse, play_pulse, clear_pulse;
    logic store_ev, play_ev;

    seq_state_t       state, state_nxt;
    logic [T_W-1:0]   timer, timer_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             wr_en;

    logic [CELL_W-1:0] cell_buf [DEPTH];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_store (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .key_n(key_store_n), .press_pulse(store_pulse)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .key_n(key_play_n), .press_pulse(play_pulse)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .key_n(key_clear_n), .press_pulse(clear_pulse)
    );

    // clear outranks store, store outranks play; losers are simply dropped
    assign store_ev = store_pulse & ~clear_pulse;
    assign play_ev  = play_pulse & ~clear_pulse & ~store_pulse;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer + 1'b1;
        count_nxt = count;
        idx_nxt   = play_idx;
        wr_en     = 1'b0;
        if (clear_pulse) begin
            state_nxt = IDLE;
            timer_nxt = '0;
            count_nxt = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    timer_nxt = '0;
                    if (store_ev) begin
                        if (!full) begin
                            wr_en     = 1'b1;
                            count_nxt = count + 1'b1;
                        end
                    end else if (play_ev && count != '0) begin
                        state_nxt = SHOW;
                        idx_nxt   = '0;
                    end
                end
                SHOW: begin
`ifdef BRAILLE_SEQ_LOOP_EN
                    if (play_ev) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else
`endif
                    if (timer == T_W'(DWELL_CYCLES - 1)) state_nxt = GAP;
                end
                GAP: begin
`ifdef BRAILLE_SEQ_LOOP_EN
                    if (play_ev) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else
`endif
                    if (timer == T_W'(GAP_CYCLES - 1)) begin
                        if (play_idx == IDX_W'(count - 1'b1)) begin
`ifdef BRAILLE_SEQ_LOOP_EN
                            state_nxt = SHOW;
`else
                            state_nxt = IDLE;
`endif
                            idx_nxt = '0;
                        end else begin
                            state_nxt = SHOW;
                            idx_nxt   = play_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            endcase
            if (state_nxt != state) timer_nxt = '0;
        end
    end

    // outputs are registered from next-state so they line up with the state they describe
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state      <= IDLE;
            timer      <= '0;
            count      <= '0;
            play_idx   <= '0;
            cell_out   <= '0;
            cell_valid <= 1'b0;
            busy       <= 1'b0;
            full       <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            count      <= count_nxt;
            play_idx   <= idx_nxt;
            cell_valid <= (state_nxt == SHOW);
            cell_out   <= (state_nxt == SHOW) ? cell_buf[idx_nxt] : '0;
            busy       <= (state_nxt != IDLE);
            full       <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    // buffer is written only in IDLE, so reads during playback never collide
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) cell_buf[count[IDX_W-1:0]] <= sw_cell;
    end

endmodule

// File: tb/tb_braille_sequencer.sv
// Scoreboard bench for braille_sequencer (DEPTH=4, DWELL=4, GAP=2, DEBOUNCE=3).
// Build with BRAILLE_SEQ_LOOP_EN defined to exercise looping playback.
module tb_braille_sequencer;
    import braille_pkg::*;

    localparam int DEPTH = 4;
    localparam int DWELL = 4;
    localparam int GAPC  = 2;
    localparam int DEB   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] sw_cell = '0;
    logic       key_store_n = 1'b1;
    logic       key_play_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [5:0] cell_out;
    logic       cell_valid, busy, full;
    logic [2:0] count;
    logic [1:0] play_idx;

    braille_sequencer #(
        .DEPTH(DEPTH), .DWELL_CYCLES(DWELL), .GAP_CYCLES(GAPC), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .sw_cell(sw_cell),
        .key_store_n(key_store_n), .key_play_n(key_play_n), .key_clear_n(key_clear_n),
        .cell_out(cell_out), .cell_valid(cell_valid), .busy(busy), .full(full),
        .count(count), .play_idx(play_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [5:0] exp_q[$];
    logic [5:0] mdl_buf[DEPTH];
    int         mdl_cnt = 0;
    bit         mon_en = 1'b1;
    bit         len_chk = 1'b1;
    bit         busy_seen = 1'b0;

    // monitor: pops expected cells on each cell_valid rise and checks dwell/gap/pass timing
    initial begin
        logic prev_v, prev_b;
        int vlen, glen, blen, nrise;
        prev_v = 1'b0; prev_b = 1'b0; vlen = 0; glen = 0; blen = 0; nrise = 0;
        forever begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
            if (busy && !prev_b) begin
                blen = 0; nrise = 0; glen = 0;
            end
            if (busy) blen++;
            if (cell_valid && !prev_v) begin
                if (mon_en) begin
                    if (exp_q.size() == 0) check("extra_cell", 1, 0);
                    else check("cell", int'(cell_out), int'(exp_q.pop_front()));
                    if (prev_b) check("gap_len", glen, GAPC);
                end
                vlen = 1; glen = 0; nrise++;
            end else if (cell_valid) begin
                vlen++;
            end
            if (busy && !cell_valid) glen++;
            if (!cell_valid && prev_v && mon_en) begin
                check("dwell_len", vlen, DWELL);
                check("blank_out", int'(cell_out), 0);
            end
            if (!busy && prev_b && mon_en && len_chk)
                check("pass_len", blen, nrise * (DWELL + GAPC));
            prev_v = cell_valid;
            prev_b = busy;
        end
    end

    task automatic press(input bit s, input bit p, input bit c);
        @(negedge clk);
        key_store_n = ~s; key_play_n = ~p; key_clear_n = ~c;
        repeat (8) @(negedge clk);
        key_store_n = 1'b1; key_play_n = 1'b1; key_clear_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic store_cell(input logic [5:0] c);
        sw_cell = c;
        press(1'b1, 1'b0, 1'b0);
        if (mdl_cnt < DEPTH) begin
            mdl_buf[mdl_cnt] = c;
            mdl_cnt++;
        end
        check("count", int'(count), mdl_cnt);
        check("full", int'(full), int'(mdl_cnt == DEPTH));
    endtask

    task automatic do_clear();
        press(1'b0, 1'b0, 1'b1);
        mdl_cnt = 0;
        check("clear_count", int'(count), 0);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_level(input bit lvl, input int limit);
        int n = 0;
        while (cell_valid != lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (cell_valid != lvl) check("valid_timeout", 1, 0);
    endtask

    task automatic play_pass();
        for (int i = 0; i < mdl_cnt; i++) exp_q.push_back(mdl_buf[i]);
        press(1'b0, 1'b1, 1'b0);
        wait_idle(200);
        check("queue_drained", exp_q.size(), 0);
        check("count_kept", int'(count), mdl_cnt);
        check("idx_home", int'(play_idx), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_count", int'(count), 0);
        check("rst_full", int'(full), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(cell_valid), 0);
        check("rst_cell", int'(cell_out), 0);
        check("rst_idx", int'(play_idx), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // A, B, C then a single pass
        store_cell(CELL_A);
        store_cell(CELL_B);
        store_cell(CELL_C);
        play_pass();

        // bouncy key: three 2-cycle glitches, then a real press
        do_clear();
        sw_cell = CELL_D;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk); key_store_n = 1'b0;
            @(negedge clk);
            @(negedge clk); key_store_n = 1'b1;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("bounce_count", int'(count), 0);
        store_cell(CELL_D);

        // overfill: fifth store ignored, playback shows first four
        do_clear();
        store_cell(CELL_E);
        store_cell(CELL_F);
        store_cell(CELL_G);
        store_cell(CELL_H);
        store_cell(CELL_I);
        play_pass();

        // clear during the SHOW of cell 1
        mon_en = 1'b0;
        @(negedge clk); key_play_n = 1'b0;
        wait_level(1'b1, 30);
        key_play_n = 1'b1;
        @(negedge clk); key_clear_n = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("clear_latency", n, 6);
        check("clear_valid", int'(cell_valid), 0);
        check("clear_busy", int'(busy), 0);
        check("clear_cnt", int'(count), 0);
        check("clear_cell", int'(cell_out), 0);
        key_clear_n = 1'b1;
        repeat (8) @(negedge clk);
        mdl_cnt = 0;
        mon_en = 1'b1;

        // play with empty buffer is ignored
        busy_seen = 1'b0;
        press(1'b0, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        check("empty_play_busy", int'(busy_seen), 0);
        check("empty_play_cnt", int'(count), 0);

        // store and play together: store wins, play dropped
        busy_seen = 1'b0;
        sw_cell = CELL_J;
        press(1'b1, 1'b1, 1'b0);
        mdl_buf[mdl_cnt] = CELL_J;
        mdl_cnt++;
        repeat (8) @(negedge clk);
        check("combo_cnt", int'(count), mdl_cnt);
        check("combo_busy", int'(busy_seen), 0);

        store_cell(CELL_K);

`ifdef BRAILLE_SEQ_LOOP_EN
        // looping: 0,1,0,1... then a play during GAP stops it
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(mdl_buf[0]);
            exp_q.push_back(mdl_buf[1]);
        end
        len_chk = 1'b0;
        @(negedge clk); key_play_n = 1'b0;
        wait_level(1'b1, 30);
        key_play_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            wait_level(1'b0, 30);
            wait_level(1'b1, 30);
        end
        repeat (5) @(negedge clk);
        key_play_n = 1'b0;
        wait_idle(30);
        key_play_n = 1'b1;
        repeat (8) @(negedge clk);
        check("loop_stop_busy", int'(busy), 0);
        check("loop_stop_cnt", int'(count), 2);
        check("loop_stop_idx", int'(play_idx), 0);
        check("loop_cells_left", exp_q.size(), 2);
        exp_q.delete();
        len_chk = 1'b1;
`else
        // single pass: a second play landing in a GAP is ignored
        store_cell(CELL_L);
        for (int i = 0; i < mdl_cnt; i++) exp_q.push_back(mdl_buf[i]);
        @(negedge clk); key_play_n = 1'b0;
        repeat (6) @(negedge clk); key_play_n = 1'b1;
        repeat (5) @(negedge clk); key_play_n = 1'b0;
        repeat (6) @(negedge clk); key_play_n = 1'b1;
        wait_idle(60);
        check("replay_queue", exp_q.size(), 0);
        check("replay_cnt", int'(count), 3);
`endif

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/braille_sequencer.md
# braille_sequencer

Record-and-playback controller for the braille cell decoder on the DE-board. Debounced pushbuttons capture 6-dot cells from the slide switches into a small buffer. A play command then presents each stored cell to the downstream decoder for a fixed dwell time, with a blank gap between cells. The block sits between the board I/O (SW, KEY) and the decoder input, replacing direct switch drive.

## Interface
Parameters:
- DEPTH, 8: buffer capacity in cells (power of 2, ≥2)
- DWELL_CYCLES, 50_000_000: clocks each cell is shown (1 s at 50 MHz)
- GAP_CYCLES, 12_500_000: clocks of blank between cells
- DEBOUNCE_CYCLES, 1_000_000: clocks a key level must be stable (20 ms)

Ports:
- CLOCK_50  in  1  sole clock, rising edge
- RESET_N  in  1  synchronous, active-low reset
- sw_cell  in  6  dot pattern, bit n = dot n+1, 1 = raised
- key_store_n  in  1  pushbutton, low = pressed (raw, asynchronous)
- key_play_n  in  1  pushbutton, low = pressed
- key_clear_n  in  1  pushbutton, low = pressed
- cell_out  out  6  cell presented to the decoder; 0 when not valid
- cell_valid  out  1  cell_out holds a stored cell
- busy  out  1  playback in progress (SHOW or GAP)
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH+1)  stored cells
- play_idx  out  $clog2(DEPTH)  index being played

## Operation
- Each key passes through a 2-flop synchroniser and a debouncer. The debouncer emits a one-cycle event on an accepted released→pressed transition only. Holding the key produces no repeats.
- Event priority when events coincide: clear > store > play. Lower-priority events in the same cycle are dropped.
- States: IDLE, SHOW, GAP.
- IDLE:
  - Store event: if not full, write sw_cell at index count and increment count. If full, ignore. A blank cell (0) is legal and represents a space.
  - Play event: if count > 0, set play_idx = 0 and go to SHOW. If count == 0, ignore.
- SHOW:
  - cell_out = buf[play_idx], cell_valid = 1, busy = 1.
  - After DWELL_CYCLES, go to GAP.
- GAP:
  - cell_out = 0, cell_valid = 0, busy = 1.
  - After GAP_CYCLES: if play_idx == count−1, go to IDLE (play_idx returns to 0). Otherwise increment play_idx and go to SHOW.
- Store and play events during SHOW/GAP are ignored, except as noted under Configuration.
- Clear event in any state: count = 0, play_idx = 0, state = IDLE, outputs blank on the next cycle. Buffer contents are not erased.
- Reset values: state IDLE, count 0, play_idx 0, cell_out 0, cell_valid 0, busy 0, full 0, debouncers in released state, timers 0. Reset mid-playback aborts immediately. Buffer RAM is not reset.

## Timing
- Key-to-event latency: 2 sync cycles plus DEBOUNCE_CYCLES of stable pressed level, then a one-cycle pulse. Bounces shorter than DEBOUNCE_CYCLES produce no event.
- Registered outputs. count and full update the cycle after a store event.
- cell_valid rises on the cycle after the play event. It stays high for exactly DWELL_CYCLES cycles, then low for exactly GAP_CYCLES.
- One full pass takes count × (DWELL_CYCLES + GAP_CYCLES) cycles from the first cell_valid rise to busy falling.
- The dwell timer is wide enough for max(DWELL_CYCLES, GAP_CYCLES). It resets to 0 on every state entry.

## Configuration
- BRAILLE_SEQ_LOOP_EN defined:
  - After the last GAP, playback wraps to play_idx 0 and SHOW instead of IDLE, repeating until a clear event or a play event.
  - A play event during SHOW/GAP stops playback: go to IDLE with play_idx 0, keep count.
- BRAILLE_SEQ_LOOP_EN undefined: single pass. Play events during playback are ignored.

## Structure
- Shared package braille_pkg:
  - state enum (IDLE, SHOW, GAP)
  - CELL_W = 6
  - named cell constants for letters A–Z, used by the decoder and benches
- Sub-module key_debounce:
  - instantiated three times
  - parameter DEBOUNCE_CYCLES
  - ports CLOCK_50, RESET_N, key_n, press_pulse
  - contains the synchroniser, stable-level counter and edge detect
- Buffer: DEPTH×6 register array inside braille_sequencer. No RAM macro.

## Test plan
All scenarios run with DEPTH=4, DWELL_CYCLES=4, GAP_CYCLES=2, DEBOUNCE_CYCLES=3.
- Store A (000001), B (000011), C (001001), then play → cell_out shows 01, 03, 09, each valid for 4 cycles with 2 blank cycles between; busy falls 18 cycles after the first valid; count stays 3.
- Key bounce of 2-cycle glitches, then a held press → exactly one store event; count 0→1.
- Store 5 cells into DEPTH=4 → full = 1 after the 4th; the 5th is ignored; count = 4; playback shows only the first 4 cells.
- Clear pressed mid-SHOW of cell 1 → next cycle cell_valid 0, busy 0, count 0; a following play is ignored.
- Play with count = 0, and store+play in the same cycle → no playback; store is accepted (count 1).
- With BRAILLE_SEQ_LOOP_EN, 2 cells stored → sequence 0, 1, 0, 1… repeats; play during GAP → IDLE, count still 2.
